jk_bank_driver: RTL and testbench

Command-side driver for a bank of N JK flip-flops. It accepts a target word over a valid/ready handshake and compares it against a shadow copy of the bank state. It then issues per-bit JK commands, limited to at most MAX_CHG bit changes per cycle, until the bank matches the target. Finally it checks the bank's Q feedback and flags any mismatch. It sits between control logic that wants a register value and the JK flip-flop bank that stores it.

---
 rtl/jk_pkg.sv | 15 +
 rtl/jk_diff_picker.sv | 23 ++
 rtl/jk_bank_driver.sv | 112 +++++++++++
 tb/tb_jk_bank_driver.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared JK command codes and driver state encoding for the JK bank driver.
package jk_pkg;

    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        CHECK = 2'd2
    } state_t;

endpackage

// File: rtl/jk_diff_picker.sv
// Selects up to MAX_CHG of the lowest-index set bits of a difference mask.
module jk_diff_picker #(
    parameter int N       = 8,
    parameter int MAX_CHG = 2
) (
    input  logic [N-1:0] i_diff,
    output logic [N-1:0] o_sel
);

    int w_cnt;

    always_comb begin
        o_sel = '0;
        w_cnt = 0;
        for (int i = 0; i < N; i++) begin
            if (i_diff[i] && (w_cnt < MAX_CHG)) begin
                o_sel[i] = 1'b1;
                w_cnt    = w_cnt + 1;
            end
        end
    end

endmodule

// File: rtl/jk_bank_driver.sv
// Drives a JK flip-flop bank toward a requested word, a few bits per cycle,
// then verifies the bank's Q feedback and resynchronises its shadow copy.
module jk_bank_driver
    import jk_pkg::*;
#(
    parameter int N          = 8,
    parameter int MAX_CHG    = 2,
    parameter int USE_TOGGLE = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           tgt_valid,
    output logic           tgt_ready,
    input  logic [N-1:0]   tgt_data,
    output logic [2*N-1:0] jk_out,
    input  logic [N-1:0]   q_fb,
    output logic           busy,
    output logic           done,
    output logic           err,
    input  logic           err_clr
);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [N-1:0]   r_tgt;
    logic [N-1:0]   r_shadow;
    logic           r_err;
    logic [N-1:0]   w_diff;
    logic [N-1:0]   w_sel;
    logic [N-1:0]   w_shadow_nxt;

    assign w_diff = r_shadow ^ r_tgt;

    jk_diff_picker #(
        .N       (N),
        .MAX_CHG (MAX_CHG)
    ) u_picker (
        .i_diff (w_diff),
        .o_sel  (w_sel)
    );

    // Shadow after this APPLY edge: commanded bits take their target value.
    assign w_shadow_nxt = (r_shadow & ~w_sel) | (r_tgt & w_sel);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (tgt_valid) begin
                    w_state_nxt = (tgt_data != r_shadow) ? APPLY : CHECK;
                end
            end
            APPLY: begin
                if (w_shadow_nxt == r_tgt) begin
                    w_state_nxt = CHECK;
                end
            end
            CHECK:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tgt    <= '0;
            r_shadow <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE:    if (tgt_valid) r_tgt <= tgt_data;
                APPLY:   r_shadow <= w_shadow_nxt;
                CHECK:   r_shadow <= q_fb;
                default: ;
            endcase
            // A mismatch seen at CHECK outranks a simultaneous clear.
            if ((r_state == CHECK) && (q_fb != r_tgt)) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    always_comb begin
        jk_out = '0;
        if (r_state == APPLY) begin
            for (int i = 0; i < N; i++) begin
                if (w_sel[i]) begin
                    if (USE_TOGGLE != 0) begin
                        jk_out[2*i +: 2] = JK_TOGGLE;
                    end else begin
                        jk_out[2*i +: 2] = r_tgt[i] ? JK_SET : JK_RESET;
                    end
                end
            end
        end
    end

    assign tgt_ready = (r_state == IDLE);
    assign busy      = (r_state == APPLY) || (r_state == CHECK);
    assign done      = (r_state == CHECK);
    assign err       = r_err;

endmodule

// File: tb/tb_jk_bank_driver.sv
// Scoreboard bench: two drivers (set/reset and toggle modes) on behavioural JK banks.
module tb_jk_bank_driver;

    typedef struct {
        int         k;
        logic [7:0] q;
        logic       e;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tgt_valid [2];
    logic [7:0]  tgt_data  [2];
    logic        tgt_ready [2];
    logic [15:0] jk_out    [2];
    logic [7:0]  q_fb      [2];
    logic        busy      [2];
    logic        done      [2];
    logic        err       [2];
    logic        err_clr   [2];
    logic [7:0]  stuck0    [2];

    logic [7:0]  m_shadow [2];
    logic [7:0]  m_bank   [2];
    logic        m_err    [2];

    exp_t        txq [$];
    logic [15:0] jkq [$];
    bit          post [2];
    exp_t        cur  [2];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    jk_bank_driver #(.N(8), .MAX_CHG(2), .USE_TOGGLE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid[0]), .tgt_ready(tgt_ready[0]),
        .tgt_data(tgt_data[0]), .jk_out(jk_out[0]), .q_fb(q_fb[0]), .busy(busy[0]),
        .done(done[0]), .err(err[0]), .err_clr(err_clr[0])
    );

    jk_bank_driver #(.N(8), .MAX_CHG(2), .USE_TOGGLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid[1]), .tgt_ready(tgt_ready[1]),
        .tgt_data(tgt_data[1]), .jk_out(jk_out[1]), .q_fb(q_fb[1]), .busy(busy[1]),
        .done(done[1]), .err(err[1]), .err_clr(err_clr[1])
    );

    for (genvar k = 0; k < 2; k++) begin : g_bank
        logic [7:0] b;
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                b <= '0;
            end else begin
                for (int i = 0; i < 8; i++) begin
                    case (jk_out[k][2*i +: 2])
                        2'b01:   b[i] <= 1'b0;
                        2'b10:   b[i] <= 1'b1;
                        2'b11:   b[i] <= ~b[i];
                        default: ;
                    endcase
                end
            end
        end
        assign q_fb[k] = b & ~stuck0[k];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        failures++;
        $display("FAIL %s: event not expected at this point", name);
    endtask

    // Monitor: consumes expected APPLY words and per-transaction results.
    initial begin
        logic [15:0] w;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (!rst_n) begin
                    post[k] = 1'b0;
                    continue;
                end
                if (post[k]) begin
                    chk("ready_after_check", {31'd0, tgt_ready[k]}, 32'd1);
                    chk("err_after_check", {31'd0, err[k]}, {31'd0, cur[k].e});
                    chk("done_one_cycle", {31'd0, done[k]}, 32'd0);
                    post[k] = 1'b0;
                end
                if (busy[k] && !done[k]) begin
                    if (jkq.size() == 0) begin
                        flag("unexpected_apply");
                    end else begin
                        w = jkq.pop_front();
                        chk("jk_apply", {16'd0, jk_out[k]}, {16'd0, w});
                    end
                end else if (done[k]) begin
                    chk("jk_zero_in_check", {16'd0, jk_out[k]}, 32'd0);
                    chk("busy_in_check", {31'd0, busy[k]}, 32'd1);
                    chk("apply_words_left", jkq.size(), 32'd0);
                    jkq.delete();
                    if (txq.size() == 0) begin
                        flag("unexpected_done");
                    end else begin
                        cur[k] = txq.pop_front();
                        chk("txn_instance", cur[k].k, k);
                        chk("q_fb_at_check", {24'd0, q_fb[k]}, {24'd0, cur[k].q});
                        post[k] = 1'b1;
                    end
                end
            end
        end
    end

    task automatic issue(input int k, input logic [7:0] t, input bit clr);
        logic [7:0]  d;
        logic [7:0]  nb;
        logic [15:0] w;
        logic [15:0] words [$];
        int          idx [$];
        int          c;
        int          n;
        bit          tog;
        exp_t        x;
        tog = (k == 1);
        d   = m_shadow[k] ^ t;
        for (int i = 0; i < 8; i++) if (d[i]) idx.push_back(i);
        c = (idx.size() + 1) / 2;
        for (int j = 0; j < idx.size(); j += 2) begin
            w = '0;
            for (int m = j; m < j + 2 && m < idx.size(); m++)
                w[2*idx[m] +: 2] = tog ? 2'b11 : (t[idx[m]] ? 2'b10 : 2'b01);
            words.push_back(w);
        end
        nb = m_bank[k];
        foreach (idx[j]) nb[idx[j]] = tog ? ~nb[idx[j]] : t[idx[j]];
        m_bank[k]   = nb;
        x.k         = k;
        x.q         = nb & ~stuck0[k];
        x.e         = (x.q != t) | (m_err[k] & ~clr);
        m_err[k]    = x.e;
        m_shadow[k] = x.q;

        err_clr[k]   = clr;
        tgt_data[k]  = t;
        tgt_valid[k] = 1'b1;
        n = 0;
        while (!tgt_ready[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!tgt_ready[k]) begin
            flag("accept_timeout");
            tgt_valid[k] = 1'b0;
            err_clr[k]   = 1'b0;
            return;
        end
        txq.push_back(x);
        foreach (words[j]) jkq.push_back(words[j]);
        @(posedge clk);
        @(negedge clk);
        tgt_valid[k] = 1'b0;
        n = 1;
        while (!done[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("done_latency", n, c + 1);
        @(negedge clk);
        err_clr[k] = 1'b0;
    endtask

    task automatic reset_model();
        for (int k = 0; k < 2; k++) begin
            m_shadow[k] = '0;
            m_bank[k]   = '0;
            m_err[k]    = 1'b0;
        end
        jkq.delete();
        txq.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tgt_valid[k] = 1'b0;
            tgt_data[k]  = '0;
            err_clr[k]   = 1'b0;
            stuck0[k]    = '0;
        end
        reset_model();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_jk_out", {16'd0, jk_out[k]}, 32'd0);
            chk("rst_ready", {31'd0, tgt_ready[k]}, 32'd1);
            chk("rst_busy", {31'd0, busy[k]}, 32'd0);
            chk("rst_done", {31'd0, done[k]}, 32'd0);
            chk("rst_err", {31'd0, err[k]}, 32'd0);
            chk("rst_q_fb", {24'd0, q_fb[k]}, 32'd0);
        end

        issue(0, 8'h0F, 1'b0);
        issue(0, 8'h0F, 1'b0);
        issue(1, 8'h0F, 1'b0);
        issue(1, 8'hF0, 1'b0);

        // Reset during the first APPLY cycle of a four-bit change.
        tgt_data[0]  = 8'h00;
        tgt_valid[0] = 1'b1;
        jkq.push_back(16'h0005);
        @(posedge clk);
        @(negedge clk);
        tgt_valid[0] = 1'b0;
        chk("pre_reset_busy", {31'd0, busy[0]}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_jk_out", {16'd0, jk_out[0]}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy[0]}, 32'd0);
        chk("mid_rst_ready", {31'd0, tgt_ready[0]}, 32'd1);
        chk("mid_rst_q_fb", {24'd0, q_fb[0]}, 32'd0);
        reset_model();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(0, 8'h03, 1'b0);
        issue(0, 8'h00, 1'b0);

        // Bank bit 5 stuck at zero.
        stuck0[0] = 8'h20;
        issue(0, 8'h20, 1'b0);
        err_clr[0] = 1'b1;
        @(negedge clk);
        err_clr[0] = 1'b0;
        m_err[0]   = 1'b0;
        chk("err_cleared", {31'd0, err[0]}, {31'd0, m_err[0]});
        issue(0, 8'h20, 1'b1);
        stuck0[0] = 8'h00;
        err_clr[0] = 1'b1;
        @(negedge clk);
        err_clr[0] = 1'b0;
        m_err[0]   = 1'b0;
        chk("err_cleared_again", {31'd0, err[0]}, {31'd0, m_err[0]});

        for (int r = 0; r < 24; r++) begin
            issue(int'($urandom_range(0, 1)), 8'($urandom), 1'b0);
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
